wb_stage: RTL and testbench

Registered, parametrised writeback stage for the pipelined core, replacing the single-cycle combinational writeback mux. Selects one of `NSRC` result sources, optionally aligns and sign-/zero-extends load data, and registers the result together with destination-register control. It holds under stall and drops the instruction on flush, feeding the register file write port and the forwarding network.

---
 rtl/wb_pkg.sv | 20 ++
 rtl/wb_load_align.sv | 44 ++++
 rtl/wb_stage.sv | 94 +++++++++
 tb/tb_wb_stage.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/wb_pkg.sv
// wb_pkg: constants shared by the writeback stage and its load aligner.
//   WB_XLEN       default datapath width
//   F3_*          load funct3 encodings
//   WB_PC4..CSR   writeback source indices into the packed source bus
package wb_pkg;

  localparam int WB_XLEN = 32;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  localparam int WB_PC4 = 0;
  localparam int WB_ALU = 1;
  localparam int WB_LD  = 2;
  localparam int WB_CSR = 3;

endpackage

// File: rtl/wb_load_align.sv
// wb_load_align: combinational load-data alignment and extension.
//   word     in  XLEN  raw load word from the LSU
//   funct3   in  3     load type (LB/LH/LW/LBU/LHU, others pass through)
//   addr_lo  in  2     byte offset of the load address
//   aligned  out XLEN  extracted, sign- or zero-extended value
// Misaligned half offsets are not trapped: only addr_lo[1] picks the half.
module wb_load_align
  import wb_pkg::*;
#(
  parameter int XLEN = WB_XLEN
) (
  input  logic [XLEN-1:0] word,
  input  logic [2:0]      funct3,
  input  logic [1:0]      addr_lo,
  output logic [XLEN-1:0] aligned
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    case (addr_lo)
      2'd0:    byte_sel = word[7:0];
      2'd1:    byte_sel = word[15:8];
      2'd2:    byte_sel = word[23:16];
      default: byte_sel = word[31:24];
    endcase
  end

  assign half_sel = addr_lo[1] ? word[31:16] : word[15:0];

  always_comb begin
    aligned = word;
    case (funct3)
      F3_LB:   aligned = XLEN'($signed(byte_sel));
      F3_LBU:  aligned = XLEN'(byte_sel);
      F3_LH:   aligned = XLEN'($signed(half_sel));
      F3_LHU:  aligned = XLEN'(half_sel);
      F3_LW:   aligned = XLEN'($signed(word[31:0]));
      default: aligned = word;
    endcase
  end

endmodule

// File: rtl/wb_stage.sv
// wb_stage: registered writeback stage.
//   clk, rst        clock, synchronous active-high reset
//   in_valid        instruction presented this cycle
//   stall, flush    hold outputs / kill the entering instruction
//   src_data        NSRC packed sources, source i at [i*XLEN +: XLEN]
//   wb_sel          source select (out-of-range selects give 0)
//   ld_funct3       load type, ld_addr_lo byte offset (alignment build only)
//   rd_addr,rd_wren destination register and its write request
//   wb_valid, wb_data, wb_rd, wb_wren  registered outputs (1-cycle latency)
// Build option: define WB_LOAD_ALIGN_EN to align/extend the LD_IDX source
// here; otherwise it passes through raw and the LSU aligns upstream.
//
// Flow control: there is no ready. An instruction moves in on every edge
// where rst, flush and stall are all low; stall freezes all outputs,
// flush (even under stall) clears wb_valid/wb_wren but keeps wb_data/wb_rd.
// wb_data/wb_rd load even when in_valid is low, so consumers must qualify
// them with wb_valid/wb_wren.
module wb_stage
  import wb_pkg::*;
#(
  parameter int XLEN   = WB_XLEN,
  parameter int NSRC   = 4,
  parameter int LD_IDX = WB_LD,
  parameter int SELW   = $clog2(NSRC)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  input  logic                 stall,
  input  logic                 flush,
  input  logic [NSRC*XLEN-1:0] src_data,
  input  logic [SELW-1:0]      wb_sel,
  input  logic [2:0]           ld_funct3,
  input  logic [1:0]           ld_addr_lo,
  input  logic [4:0]           rd_addr,
  input  logic                 rd_wren,
  output logic                 wb_valid,
  output logic [XLEN-1:0]      wb_data,
  output logic [4:0]           wb_rd,
  output logic                 wb_wren
);

  logic [XLEN-1:0] ld_word;
  logic [XLEN-1:0] ld_result;
  logic [XLEN-1:0] result;

  assign ld_word = src_data[LD_IDX*XLEN +: XLEN];

`ifdef WB_LOAD_ALIGN_EN
  wb_load_align #(
    .XLEN(XLEN)
  ) u_align (
    .word   (ld_word),
    .funct3 (ld_funct3),
    .addr_lo(ld_addr_lo),
    .aligned(ld_result)
  );
`else
  // Load control is meaningless without the aligner; fold it into a sink.
  logic unused_ld_ctrl;
  assign unused_ld_ctrl = ^{ld_funct3, ld_addr_lo};
  assign ld_result      = ld_word;
`endif

  // Only indices below NSRC can match, so a select past the last source
  // (possible when NSRC is not a power of two) falls through to zero.
  always_comb begin
    result = '0;
    for (int i = 0; i < NSRC; i++) begin
      if (wb_sel == SELW'(i)) begin
        result = (i == LD_IDX) ? ld_result : src_data[i*XLEN +: XLEN];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wb_valid <= 1'b0;
      wb_data  <= '0;
      wb_rd    <= 5'd0;
      wb_wren  <= 1'b0;
    end else if (flush) begin
      wb_valid <= 1'b0;
      wb_wren  <= 1'b0;
    end else if (!stall) begin
      wb_valid <= in_valid;
      wb_data  <= result;
      wb_rd    <= rd_addr;
      // x0 is hardwired to zero, so never request a write to it.
      wb_wren  <= in_valid & rd_wren & (rd_addr != 5'd0);
    end
  end

endmodule

// File: tb/tb_wb_stage.sv
module tb_wb_stage;
  import wb_pkg::*;

  localparam int XLEN = 32;
  localparam int W    = 2 + 5 + XLEN;   // {valid, wren, rd, data}

`ifdef WB_LOAD_ALIGN_EN
  localparam bit ALIGN = 1'b1;
`else
  localparam bit ALIGN = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst;
  logic            in_valid, stall, flush;
  logic [XLEN-1:0] pc4, alu, ld, csr;
  logic [1:0]      wb_sel;
  logic [2:0]      ld_funct3;
  logic [1:0]      ld_addr_lo;
  logic [4:0]      rd_addr;
  logic            rd_wren;

  logic [4*XLEN-1:0] src_data;
  logic [3*XLEN-1:0] src_data3;
  assign src_data  = {csr, ld, alu, pc4};
  assign src_data3 = {ld, alu, pc4};

  logic            wb_valid, wb_wren;
  logic [XLEN-1:0] wb_data;
  logic [4:0]      wb_rd;

  logic            wb_valid3, wb_wren3;
  logic [XLEN-1:0] wb_data3;
  logic [4:0]      wb_rd3;

  wb_stage #(.XLEN(XLEN), .NSRC(4), .LD_IDX(WB_LD)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .stall(stall), .flush(flush),
    .src_data(src_data), .wb_sel(wb_sel), .ld_funct3(ld_funct3),
    .ld_addr_lo(ld_addr_lo), .rd_addr(rd_addr), .rd_wren(rd_wren),
    .wb_valid(wb_valid), .wb_data(wb_data), .wb_rd(wb_rd), .wb_wren(wb_wren)
  );

  // Three-source instance: wb_sel = 3 is out of range here.
  wb_stage #(.XLEN(XLEN), .NSRC(3), .LD_IDX(WB_LD)) dut3 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .stall(stall), .flush(flush),
    .src_data(src_data3), .wb_sel(wb_sel), .ld_funct3(ld_funct3),
    .ld_addr_lo(ld_addr_lo), .rd_addr(rd_addr), .rd_wren(rd_wren),
    .wb_valid(wb_valid3), .wb_data(wb_data3), .wb_rd(wb_rd3), .wb_wren(wb_wren3)
  );

  // ---------------- scoreboard ----------------
  logic [W-1:0] exp_q[$];
  int n_checks = 0;
  int n_fails  = 0;

  // Push the expected outputs for the inputs currently driven, advance one
  // edge, then pop and compare away from the edge.
  task automatic tick(input string tag, input logic ev, input logic [XLEN-1:0] ed,
                      input logic [4:0] erd, input logic ewe);
    logic [W-1:0] exp_v;
    logic [W-1:0] obs_v;
    exp_q.push_back({ev, ewe, erd, ed});
    @(posedge clk);
    #1;
    exp_v = exp_q.pop_front();
    obs_v = {wb_valid, wb_wren, wb_rd, wb_data};
    n_checks++;
    assert (obs_v === exp_v) else begin
      n_fails++;
      $error("FAIL %s: observed valid=%b wren=%b rd=%0d data=%h, expected valid=%b wren=%b rd=%0d data=%h",
             tag, obs_v[W-1], obs_v[W-2], obs_v[XLEN+4:XLEN], obs_v[XLEN-1:0],
             exp_v[W-1], exp_v[W-2], exp_v[XLEN+4:XLEN], exp_v[XLEN-1:0]);
    end
  endtask

  task automatic check3(input string tag, input logic [XLEN-1:0] ed, input logic ev);
    n_checks++;
    assert ({wb_valid3, wb_data3} === {ev, ed}) else begin
      n_fails++;
      $error("FAIL %s: observed valid=%b data=%h, expected valid=%b data=%h",
             tag, wb_valid3, wb_data3, ev, ed);
    end
  endtask

  localparam logic [XLEN-1:0] LDW = 32'h80FF_7F01;

  // ---------------- directed sequence ----------------
  initial begin
    rst = 1'b1; stall = 1'b0; flush = 1'b0;
    pc4 = 32'h0000_0100; alu = 32'h0000_1234; ld = LDW; csr = 32'h0000_C5C5;
    in_valid = 1'b1; wb_sel = 2'd1; ld_funct3 = F3_LW; ld_addr_lo = 2'd0;
    rd_addr = 5'd5; rd_wren = 1'b1;

    // Reset wins over a live instruction.
    tick("reset_0", 1'b0, 32'h0, 5'd0, 1'b0);
    tick("reset_1", 1'b0, 32'h0, 5'd0, 1'b0);

    rst = 1'b0;
    tick("sel_alu", 1'b1, 32'h0000_1234, 5'd5, 1'b1);
    wb_sel = 2'd0; rd_addr = 5'd1;
    tick("sel_pc4", 1'b1, 32'h0000_0100, 5'd1, 1'b1);
    wb_sel = 2'd3; rd_addr = 5'd31;
    tick("sel_csr", 1'b1, 32'h0000_C5C5, 5'd31, 1'b1);

    // Load alignment on source 2.
    wb_sel = 2'd2; rd_addr = 5'd7;
    ld_funct3 = F3_LB;  ld_addr_lo = 2'd3;
    tick("ld_lb3",  1'b1, ALIGN ? 32'hFFFF_FF80 : LDW, 5'd7, 1'b1);
    ld_funct3 = F3_LBU; ld_addr_lo = 2'd1;
    tick("ld_lbu1", 1'b1, ALIGN ? 32'h0000_007F : LDW, 5'd7, 1'b1);
    ld_funct3 = F3_LH;  ld_addr_lo = 2'd2;
    tick("ld_lh2",  1'b1, ALIGN ? 32'hFFFF_80FF : LDW, 5'd7, 1'b1);
    ld_funct3 = F3_LH;  ld_addr_lo = 2'd3;
    tick("ld_lh3_misaligned", 1'b1, ALIGN ? 32'hFFFF_80FF : LDW, 5'd7, 1'b1);
    ld_funct3 = F3_LHU; ld_addr_lo = 2'd0;
    tick("ld_lhu0", 1'b1, ALIGN ? 32'h0000_7F01 : LDW, 5'd7, 1'b1);
    ld_funct3 = F3_LW;  ld_addr_lo = 2'd0;
    tick("ld_lw",   1'b1, LDW, 5'd7, 1'b1);
    ld_funct3 = 3'b011; ld_addr_lo = 2'd2;
    tick("ld_other_raw", 1'b1, LDW, 5'd7, 1'b1);
    // Non-load source must not be aligned even with a load funct3.
    ld_funct3 = F3_LB; ld_addr_lo = 2'd3; wb_sel = 2'd1; alu = 32'h8765_4321;
    tick("alu_not_aligned", 1'b1, 32'h8765_4321, 5'd7, 1'b1);

    // x0 guard and invalid instruction still loading data/rd.
    rd_addr = 5'd0; alu = 32'h0000_00AB;
    tick("x0_no_wren", 1'b1, 32'h0000_00AB, 5'd0, 1'b0);
    in_valid = 1'b0; rd_addr = 5'd9; alu = 32'h0000_0CDE;
    tick("invalid_loads", 1'b0, 32'h0000_0CDE, 5'd9, 1'b0);

    // Range guard on the three-source instance.
    in_valid = 1'b1; wb_sel = 2'd3; rd_addr = 5'd4;
    tick("sel3_main", 1'b1, 32'h0000_C5C5, 5'd4, 1'b1);
    check3("sel3_range_nsrc3", 32'h0, 1'b1);

    // Stall and flush.
    wb_sel = 2'd1; alu = 32'hAAAA_AAAA; rd_addr = 5'd10;
    tick("load_a", 1'b1, 32'hAAAA_AAAA, 5'd10, 1'b1);
    stall = 1'b1; alu = 32'hBBBB_BBBB; rd_addr = 5'd11;
    for (int k = 0; k < 3; k++) begin
      tick($sformatf("stall_hold_%0d", k), 1'b1, 32'hAAAA_AAAA, 5'd10, 1'b1);
    end
    flush = 1'b1;
    tick("stall_flush", 1'b0, 32'hAAAA_AAAA, 5'd10, 1'b0);
    stall = 1'b0;
    tick("flush_only", 1'b0, 32'hAAAA_AAAA, 5'd10, 1'b0);
    flush = 1'b0;
    tick("after_flush", 1'b1, 32'hBBBB_BBBB, 5'd11, 1'b1);
    stall = 1'b1; rst = 1'b1;
    tick("reset_mid_stall", 1'b0, 32'h0, 5'd0, 1'b0);
    rst = 1'b0;
    tick("stall_after_reset", 1'b0, 32'h0, 5'd0, 1'b0);

    // Back-to-back valid instructions, no bubbles.
    stall = 1'b0;
    for (int k = 0; k < 4; k++) begin
      alu = 32'h1111_1111 * (k + 1) + $urandom_range(0, 255);
      rd_addr = 5'(k + 20);
      tick($sformatf("b2b_%0d", k), 1'b1, alu, 5'(k + 20), 1'b1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
